// File: rtl/sparrow_mem_arbiter.sv
// sparrow_mem_arbiter: shares one single-port memory between fetch and LSU.
// Optional starvation guard for fetch: define SPARROW_ARB_STARVE_GUARD_EN.
module sparrow_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_if_req,
    input  logic [ADDR_W-1:0]     i_if_addr,
    output logic                  o_if_gnt,
    output logic                  o_if_rvalid,
    output logic [DATA_W-1:0]     o_if_rdata,
    input  logic                  i_d_req,
    input  logic                  i_d_we,
    input  logic [ADDR_W-1:0]     i_d_addr,
    input  logic [DATA_W-1:0]     i_d_wdata,
    input  logic [DATA_W/8-1:0]   i_d_be,
    output logic                  o_d_gnt,
    output logic                  o_d_rvalid,
    output logic [DATA_W-1:0]     o_d_rdata,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    output logic [DATA_W/8-1:0]   o_mem_be,
    input  logic [DATA_W-1:0]     i_mem_rd_data
);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    if (MAX_STARVE < 1 || MAX_STARVE > 15) begin : g_bad_max_starve
        $error("MAX_STARVE must be within 1..15");
    end

    logic       if_gnt;
    logic       d_gnt;
    logic [1:0] owner_q;

`ifdef SPARROW_ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

    logic [3:0] starve_q;
    logic       force_if;

    assign force_if = (starve_q == STARVE_MAX) & i_if_req & i_d_req;
    assign d_gnt    = i_reset_n & i_d_req & ~force_if;
    assign if_gnt   = i_reset_n & i_if_req & (~i_d_req | force_if);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            starve_q <= 4'd0;
        end else if (!i_if_req || if_gnt) begin
            starve_q <= 4'd0;
        end else if (starve_q != STARVE_MAX) begin
            starve_q <= starve_q + 4'd1;
        end
    end
`else
    assign d_gnt  = i_reset_n & i_d_req;
    assign if_gnt = i_reset_n & i_if_req & ~i_d_req;
`endif

    assign o_if_gnt  = if_gnt;
    assign o_d_gnt   = d_gnt;
    assign o_mem_req = if_gnt | d_gnt;

    // Idle cycles keep the D-port values on the bus to avoid extra toggling.
    always_comb begin
        o_mem_we    = 1'b0;
        o_mem_addr  = i_d_addr;
        o_mem_wdata = i_d_wdata;
        o_mem_be    = i_d_be;
        unique case (1'b1)
            if_gnt: begin
                o_mem_addr = i_if_addr;
                o_mem_be   = '1;
            end
            d_gnt: begin
                o_mem_we = i_d_we;
            end
            default: begin
                o_mem_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            owner_q <= OWN_NONE;
        end else begin
            unique case (1'b1)
                if_gnt:            owner_q <= OWN_IF;
                (d_gnt & ~i_d_we): owner_q <= OWN_D;
                default:           owner_q <= OWN_NONE;
            endcase
        end
    end

    assign o_if_rvalid = (owner_q == OWN_IF);
    assign o_d_rvalid  = (owner_q == OWN_D);
    assign o_if_rdata  = i_mem_rd_data;
    assign o_d_rdata   = i_mem_rd_data;

endmodule
